// File: rtl/rvh_l1d_pkg.sv
// Shared types and defaults for the L1D PLRU update controller.
package rvh_l1d_pkg;

    localparam int unsigned PLRU_STARVE_MAX = 4;

    // Hit-queue entries are sized for the largest supported set/way indices.
    localparam int unsigned HQ_SET_W = 12;
    localparam int unsigned HQ_WAY_W = 6;

    typedef struct packed {
        logic [HQ_SET_W-1:0] set_idx;
        logic [HQ_WAY_W-1:0] way_idx;
    } plru_hq_entry_t;

    function automatic logic [31:0] perf_sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/rvh_l1d_plru_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr wins, one-hot grant.
module rvh_l1d_plru_rr_arb #(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < int'(N); i++) begin
            idx = (int'(ptr) + i) % int'(N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvh_l1d_plru_ctrl.sv
// L1D PLRU controller: queues hit reports per port and shares the PLRU port with refill victim reads.
// Optional perf counters enabled with RVH_L1D_PLRU_PERF_EN.
module rvh_l1d_plru_ctrl
    import rvh_l1d_pkg::*;
#(
    parameter int unsigned HIT_PORT_N = 2,
    parameter int unsigned ENTRY_NUM  = 32,
    parameter int unsigned WAY_NUM    = 4,
    parameter int unsigned HQ_DEPTH   = 2,
    parameter int unsigned STARVE_MAX = PLRU_STARVE_MAX
) (
    input  logic                                          clk,
    input  logic                                          rstn,
    input  logic [HIT_PORT_N-1:0]                         hit_vld_i,
    input  logic [HIT_PORT_N-1:0][$clog2(ENTRY_NUM)-1:0]  hit_set_i,
    input  logic [HIT_PORT_N-1:0][$clog2(WAY_NUM)-1:0]    hit_way_i,
    input  logic                                          refill_req_vld_i,
    input  logic [$clog2(ENTRY_NUM)-1:0]                  refill_req_set_i,
    output logic                                          refill_req_rdy_o,
    output logic                                          refill_resp_vld_o,
    output logic [$clog2(WAY_NUM)-1:0]                    refill_resp_way_o,
    output logic                                          plru_upd_en_hit_o,
    output logic [$clog2(ENTRY_NUM)-1:0]                  plru_upd_set_idx_hit_o,
    output logic [$clog2(WAY_NUM)-1:0]                    plru_upd_way_idx_hit_o,
    output logic                                          plru_rd_en_refill_o,
    output logic [$clog2(ENTRY_NUM)-1:0]                  plru_rd_idx_refill_o,
    input  logic [$clog2(WAY_NUM)-1:0]                    plru_rd_dat_refill_i
`ifdef RVH_L1D_PLRU_PERF_EN
    ,
    output logic [31:0]                                   perf_hit_drop_o,
    output logic [31:0]                                   perf_hit_grant_o,
    output logic [31:0]                                   perf_refill_o
`endif
);

    localparam int unsigned SET_W  = $clog2(ENTRY_NUM);
    localparam int unsigned WAY_W  = $clog2(WAY_NUM);
    localparam int unsigned PTR_W  = (HQ_DEPTH > 1) ? $clog2(HQ_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(HQ_DEPTH + 1);
    localparam int unsigned PORT_W = (HIT_PORT_N > 1) ? $clog2(HIT_PORT_N) : 1;
    localparam int unsigned STV_W  = $clog2(STARVE_MAX + 1);

    plru_hq_entry_t        hq_mem    [HIT_PORT_N][HQ_DEPTH];
    logic [PTR_W-1:0]      hq_wr_ptr [HIT_PORT_N];
    logic [PTR_W-1:0]      hq_rd_ptr [HIT_PORT_N];
    logic [CNT_W-1:0]      hq_cnt    [HIT_PORT_N];

    logic [HIT_PORT_N-1:0] hq_nempty;
    logic [HIT_PORT_N-1:0] hq_full;
    logic [HIT_PORT_N-1:0] hq_push;
    logic [HIT_PORT_N-1:0] hq_pop;
    logic [HIT_PORT_N-1:0] hq_drop;
    logic [HIT_PORT_N-1:0] hit_req;
    logic [HIT_PORT_N-1:0] hit_gnt;
    logic [PORT_W-1:0]     gnt_idx;
    logic [PORT_W-1:0]     rr_ptr_q;
    logic [STV_W-1:0]      starve_cnt_q;
    logic                  any_pend;
    logic                  refill_fire;
    plru_hq_entry_t        hq_head;

    function automatic logic [PTR_W-1:0] hq_ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(HQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Refill wins unless hits have been starved for STARVE_MAX refill grants.
    always_comb begin
        hq_nempty = '0;
        hq_full   = '0;
        for (int p = 0; p < int'(HIT_PORT_N); p++) begin
            hq_nempty[p] = (hq_cnt[p] != '0);
            hq_full[p]   = (hq_cnt[p] == CNT_W'(HQ_DEPTH));
        end
        any_pend         = |hq_nempty;
        refill_req_rdy_o = !((starve_cnt_q == STV_W'(STARVE_MAX)) && any_pend);
        refill_fire      = refill_req_vld_i && refill_req_rdy_o;
        hit_req          = refill_fire ? '0 : hq_nempty;
    end

    rvh_l1d_plru_rr_arb #(
        .N     (HIT_PORT_N),
        .PTR_W (PORT_W)
    ) u_rr_arb (
        .req (hit_req),
        .ptr (rr_ptr_q),
        .gnt (hit_gnt)
    );

    // Pop the granted head; a push to a full queue survives only if that queue pops.
    always_comb begin
        gnt_idx = '0;
        for (int p = 0; p < int'(HIT_PORT_N); p++) begin
            if (hit_gnt[p]) gnt_idx = PORT_W'(p);
        end
        hq_pop  = hit_gnt;
        hq_push = hit_vld_i & (~hq_full | hq_pop);
        hq_drop = hit_vld_i & ~hq_push;
        hq_head = hq_mem[gnt_idx][hq_rd_ptr[gnt_idx]];

        plru_upd_en_hit_o      = |hit_gnt;
        plru_upd_set_idx_hit_o = SET_W'(hq_head.set_idx);
        plru_upd_way_idx_hit_o = WAY_W'(hq_head.way_idx);
        plru_rd_en_refill_o    = refill_fire;
        plru_rd_idx_refill_o   = refill_req_set_i;
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < int'(HIT_PORT_N); p++) begin
            if (hq_push[p]) begin
                hq_mem[p][hq_wr_ptr[p]] <= '{set_idx: HQ_SET_W'(hit_set_i[p]),
                                             way_idx: HQ_WAY_W'(hit_way_i[p])};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int p = 0; p < int'(HIT_PORT_N); p++) begin
                hq_wr_ptr[p] <= '0;
                hq_rd_ptr[p] <= '0;
                hq_cnt[p]    <= '0;
            end
        end else begin
            for (int p = 0; p < int'(HIT_PORT_N); p++) begin
                if (hq_push[p]) hq_wr_ptr[p] <= hq_ptr_inc(hq_wr_ptr[p]);
                if (hq_pop[p])  hq_rd_ptr[p] <= hq_ptr_inc(hq_rd_ptr[p]);
                case ({hq_push[p], hq_pop[p]})
                    2'b10:   hq_cnt[p] <= hq_cnt[p] + CNT_W'(1);
                    2'b01:   hq_cnt[p] <= hq_cnt[p] - CNT_W'(1);
                    default: hq_cnt[p] <= hq_cnt[p];
                endcase
            end
        end
    end

    // Arbitration pointer and hit starvation tracking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q     <= '0;
            starve_cnt_q <= '0;
        end else begin
            if (|hit_gnt) begin
                rr_ptr_q <= (gnt_idx == PORT_W'(HIT_PORT_N - 1)) ? '0 : gnt_idx + PORT_W'(1);
            end
            if (|hit_gnt) begin
                starve_cnt_q <= '0;
            end else if (refill_fire && any_pend) begin
                if (starve_cnt_q != STV_W'(STARVE_MAX)) starve_cnt_q <= starve_cnt_q + STV_W'(1);
            end else if (!any_pend) begin
                starve_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            refill_resp_vld_o <= 1'b0;
            refill_resp_way_o <= '0;
        end else begin
            refill_resp_vld_o <= refill_fire;
            if (refill_fire) refill_resp_way_o <= plru_rd_dat_refill_i;
        end
    end

`ifdef RVH_L1D_PLRU_PERF_EN
    logic [31:0] drop_num;

    always_comb begin
        drop_num = '0;
        for (int p = 0; p < int'(HIT_PORT_N); p++) begin
            drop_num = drop_num + 32'(hq_drop[p]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_hit_drop_o  <= '0;
            perf_hit_grant_o <= '0;
            perf_refill_o    <= '0;
        end else begin
            perf_hit_drop_o  <= perf_sat_add(perf_hit_drop_o, drop_num);
            perf_hit_grant_o <= perf_sat_add(perf_hit_grant_o, 32'(|hit_gnt));
            perf_refill_o    <= perf_sat_add(perf_refill_o, 32'(refill_fire));
        end
    end
`else
    logic unused_drop;
    assign unused_drop = |hq_drop;
`endif

endmodule
